// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared op codes, reset levels and FSM encoding for the memory-access stage
package mem_access_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic RstDisable = 1'b1;
  localparam logic [3:0] EXE_NOP_OP = 4'h0;
  localparam logic [3:0] EXE_ADD_OP = 4'h1;
  localparam logic [3:0] EXE_SUB_OP = 4'h2;
  localparam logic [3:0] EXE_AND_OP = 4'h3;
  localparam logic [3:0] EXE_OR_OP = 4'h4;
  localparam logic [3:0] EXE_XOR_OP = 4'h5;
  localparam logic [3:0] EXE_LW_OP = 4'h8;
  localparam logic [3:0] EXE_SW_OP = 4'h9;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_e;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op == EXE_LW_OP || op == EXE_SW_OP;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 8-bit wait counter flagging when a memory access has waited TIMEOUT cycles
module mem_wait_timer
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  // clear has priority; count only while waiting without ack
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage issuing LW/SW to data memory and forwarding results to write-back
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  output logic              stall_o,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              align_err,
  output logic              bus_err
);
  state_e state_q, state_d;
  logic [4:0] wd_q, wd_d, wb_wd_q, wb_wd_d;
  logic wreg_q, wreg_d, dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic wb_valid_q, wb_valid_d, wb_wreg_q, wb_wreg_d;
  logic align_err_q, align_err_d, bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d, wb_wdata_q, wb_wdata_d;
  logic expired;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE),
    .en_i(state_q == WAIT_ACK && !dm_ack),
    .expired_o(expired)
  );

  // next state: accept in IDLE, complete on ack (ack beats timeout), give up on expiry
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    wreg_d = wreg_q;
    dm_req_d = 1'b0;
    dm_we_d = dm_we_q;
    dm_addr_d = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = 1'b0;
    wb_wd_d = wb_wd_q;
    wb_wreg_d = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    align_err_d = 1'b0;
    bus_err_d = bus_err_q;
    if (state_q == IDLE) begin
      if (valid_i && !is_mem_op(aluop_i)) begin
        wb_valid_d = 1'b1;
        wb_wd_d = wd_i;
        wb_wreg_d = wreg_i;
        wb_wdata_d = wdata_i;
      end else if (valid_i && mem_addr_i[1:0] != 2'b00) begin
        align_err_d = 1'b1;
        wb_valid_d = 1'b1;
        wb_wd_d = wd_i;
        wb_wreg_d = 1'b0;
        wb_wdata_d = 32'd0;
      end else if (valid_i) begin
        state_d = WAIT_ACK;
        wd_d = wd_i;
        wreg_d = wreg_i;
        dm_req_d = 1'b1;
        dm_we_d = aluop_i == EXE_SW_OP;
        dm_addr_d = mem_addr_i;
        dm_wdata_d = reg2_i;
      end
    end else if (dm_ack || expired) begin
      state_d = IDLE;
      wb_valid_d = 1'b1;
      wb_wd_d = wd_q;
      wb_wreg_d = dm_ack && !dm_we_q && wreg_q;
      wb_wdata_d = dm_ack && !dm_we_q ? dm_rdata : 32'd0;
      bus_err_d = bus_err_q || !dm_ack;
    end else begin
      dm_req_d = 1'b1;
    end
  end

  // state and output registers; reset abandons any pending access
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      state_q <= IDLE;
      wd_q <= 5'd0;
      wreg_q <= 1'b0;
      dm_req_q <= 1'b0;
      dm_we_q <= 1'b0;
      dm_addr_q <= '0;
      dm_wdata_q <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_wd_q <= 5'd0;
      wb_wreg_q <= 1'b0;
      wb_wdata_q <= 32'd0;
      align_err_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      wreg_q <= wreg_d;
      dm_req_q <= dm_req_d;
      dm_we_q <= dm_we_d;
      dm_addr_q <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_wd_q <= wb_wd_d;
      wb_wreg_q <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
      align_err_q <= align_err_d;
      bus_err_q <= bus_err_d;
    end

  assign stall_o = state_q == WAIT_ACK;
  assign dm_req = dm_req_q;
  assign dm_we = dm_we_q;
  assign dm_addr = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_wd = wb_wd_q;
  assign wb_wreg = wb_wreg_q;
  assign wb_wdata = wb_wdata_q;
  assign align_err = align_err_q;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: vector table, directed memory sequences and randomized transactions vs a reference model
module tb_mem_access;
  import mem_access_pkg::*;
  localparam int AW = 10;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic valid_i = 1'b0, wreg_i = 1'b0, dm_ack = 1'b0;
  logic [4:0] wd_i = '0;
  logic [31:0] wdata_i = '0, reg2_i = '0, dm_rdata = '0;
  logic [3:0] aluop_i = '0;
  logic [AW-1:0] mem_addr_i = '0;
  logic stall_o, dm_req, dm_we, wb_valid, wb_wreg, align_err, bus_err;
  logic [AW-1:0] dm_addr;
  logic [31:0] dm_wdata, wb_wdata;
  logic [4:0] wb_wd;
  int n_tests = 0, n_fail = 0;
  logic exp_bus_err = 1'b0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_valid(wb_valid),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .align_err(align_err),
    .bus_err(bus_err)
  );

  typedef struct {
    logic [3:0] op;
    logic [4:0] wd;
    logic wreg;
    logic [31:0] wdata;
    logic [AW-1:0] addr;
    logic e_wreg;
    logic [31:0] e_wdata;
    logic e_align;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_mem(input logic [3:0] op);
    return op == EXE_LW_OP || op == EXE_SW_OP;
  endfunction

  task automatic single(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [AW-1:0] addr,
                        input logic e_wreg, input logic [31:0] e_wdata, input logic e_align);
    valid_i = 1'b1; aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_addr_i = addr; reg2_i = $urandom; dm_ack = 1'($urandom % 2);
    step;
    chk1("single_wb_valid", wb_valid, 1'b1);
    if (!e_align) chk("single_wb_wd", {27'd0, wb_wd}, {27'd0, wd});
    chk1("single_wb_wreg", wb_wreg, e_wreg);
    chk("single_wb_wdata", wb_wdata, e_wdata);
    chk1("single_align_err", align_err, e_align);
    chk1("single_dm_req", dm_req, 1'b0);
    chk1("single_stall", stall_o, 1'b0);
    chk1("single_bus_err", bus_err, exp_bus_err);
    valid_i = 1'b0; dm_ack = 1'b0;
  endtask

  // d = number of wait cycles without ack before the ack cycle
  task automatic mem_op(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [AW-1:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int d);
    int waits;
    logic timeout, is_sw;
    timeout = d >= TO;
    waits = timeout ? TO : d + 1;
    is_sw = op == EXE_SW_OP;
    valid_i = 1'b1; aluop_i = op; wd_i = wd; wreg_i = wreg; mem_addr_i = addr;
    reg2_i = reg2; wdata_i = $urandom; dm_ack = 1'b0;
    step;
    for (int i = 0; i < waits; i++) begin
      chk1("mem_stall", stall_o, 1'b1);
      chk1("mem_dm_req", dm_req, 1'b1);
      chk1("mem_dm_we", dm_we, is_sw);
      chk("mem_dm_addr", 32'(dm_addr), 32'(addr));
      chk("mem_dm_wdata", dm_wdata, reg2);
      chk1("mem_wb_valid_wait", wb_valid, 1'b0);
      valid_i = 1'($urandom % 2); aluop_i = 4'($urandom); wd_i = 5'($urandom);
      wreg_i = 1'($urandom % 2); mem_addr_i = AW'($urandom); reg2_i = $urandom; wdata_i = $urandom;
      dm_ack = i == d;
      dm_rdata = i == d ? rdata : $urandom;
      step;
    end
    if (timeout) exp_bus_err = 1'b1;
    chk1("done_stall", stall_o, 1'b0);
    chk1("done_dm_req", dm_req, 1'b0);
    chk1("done_wb_valid", wb_valid, 1'b1);
    chk("done_wb_wd", {27'd0, wb_wd}, {27'd0, wd});
    chk1("done_wb_wreg", wb_wreg, (timeout || is_sw) ? 1'b0 : wreg);
    chk("done_wb_wdata", wb_wdata, (timeout || is_sw) ? 32'd0 : rdata);
    chk1("done_bus_err", bus_err, exp_bus_err);
    chk1("done_align_err", align_err, 1'b0);
    valid_i = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic idle_cycle;
    valid_i = 1'b0; dm_ack = 1'($urandom % 2); dm_rdata = $urandom;
    step;
    chk1("idle_wb_valid", wb_valid, 1'b0);
    chk1("idle_dm_req", dm_req, 1'b0);
    chk1("idle_stall", stall_o, 1'b0);
    chk1("idle_align_err", align_err, 1'b0);
    chk1("idle_bus_err", bus_err, exp_bus_err);
    dm_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_stall"}, stall_o, 1'b0);
    chk1({tag, "_dm_req"}, dm_req, 1'b0);
    chk1({tag, "_dm_we"}, dm_we, 1'b0);
    chk({tag, "_dm_addr"}, 32'(dm_addr), 32'd0);
    chk({tag, "_dm_wdata"}, dm_wdata, 32'd0);
    chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_wb_wd"}, {27'd0, wb_wd}, 32'd0);
    chk1({tag, "_wb_wreg"}, wb_wreg, 1'b0);
    chk({tag, "_wb_wdata"}, wb_wdata, 32'd0);
    chk1({tag, "_align_err"}, align_err, 1'b0);
    chk1({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    logic [3:0] ops[8];
    vt[0] = '{EXE_ADD_OP, 5'd5, 1'b1, 32'h7, 10'h000, 1'b1, 32'h7, 1'b0};
    vt[1] = '{EXE_SUB_OP, 5'd31, 1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vt[2] = '{EXE_OR_OP, 5'd1, 1'b0, 32'hA5A5_0000, 10'h004, 1'b0, 32'hA5A5_0000, 1'b0};
    vt[3] = '{EXE_LW_OP, 5'd9, 1'b1, 32'h1234, 10'h013, 1'b0, 32'h0, 1'b1};
    vt[4] = '{EXE_SW_OP, 5'd2, 1'b1, 32'h55, 10'h022, 1'b0, 32'h0, 1'b1};
    vt[5] = '{EXE_XOR_OP, 5'd7, 1'b1, 32'hCAFE, 10'h001, 1'b1, 32'hCAFE, 1'b0};
    ops = '{EXE_NOP_OP, EXE_ADD_OP, EXE_SUB_OP, EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_LW_OP, EXE_SW_OP};
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    idle_cycle;
    for (int i = 0; i < 6; i++)
      single(vt[i].op, vt[i].wd, vt[i].wreg, vt[i].wdata, vt[i].addr, vt[i].e_wreg, vt[i].e_wdata, vt[i].e_align);
    idle_cycle;
    mem_op(EXE_LW_OP, 5'd3, 1'b1, 10'h010, 32'h0, 32'hDEAD_BEEF, 2);
    idle_cycle;
    mem_op(EXE_SW_OP, 5'd4, 1'b1, 10'h020, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    single(EXE_ADD_OP, 5'd6, 1'b1, 32'h99, 10'h0, 1'b1, 32'h99, 1'b0);
    idle_cycle;
    mem_op(EXE_LW_OP, 5'd8, 1'b1, 10'h100, 32'h0, 32'h0BAD_F00D, TO - 1);
    mem_op(EXE_LW_OP, 5'd10, 1'b1, 10'h040, 32'h0, 32'h1111_2222, 100);
    idle_cycle;
    idle_cycle;
    valid_i = 1'b1; aluop_i = EXE_LW_OP; wd_i = 5'd12; wreg_i = 1'b1; mem_addr_i = 10'h044;
    step;
    valid_i = 1'b0;
    chk1("rst_wait_dm_req", dm_req, 1'b1);
    step;
    #2 rst = 1'b0;
    #1;
    exp_bus_err = 1'b0;
    chk_all_zero("async_rst");
    @(negedge clk) rst = 1'b1;
    idle_cycle;
    idle_cycle;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic [AW-1:0] addr;
      logic e_wreg, e_align, wreg;
      logic [31:0] wdata, e_wdata;
      logic [4:0] wd;
      op = ops[$urandom % 8];
      addr = AW'($urandom);
      if ($urandom % 5 != 0) addr = addr - AW'(addr % 4);
      wreg = 1'($urandom % 2);
      wdata = $urandom;
      wd = 5'($urandom);
      if ($urandom % 6 == 0) idle_cycle;
      else if (is_mem(op) && addr % 4 == 0)
        mem_op(op, wd, wreg, addr, $urandom, $urandom, int'($urandom % 6));
      else begin
        e_align = is_mem(op) && addr % 4 != 0;
        e_wreg = e_align ? 1'b0 : wreg;
        e_wdata = e_align ? 32'd0 : wdata;
        single(op, wd, wreg, wdata, addr, e_wreg, e_wdata, e_align);
      end
    end
    idle_cycle;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
